bk_adder_pipe: RTL and testbench



---
 rtl/bk_pkg.sv | 30 +++
 rtl/bk_prefix_tree.sv | 55 +++++
 rtl/bk_adder_pipe.sv | 186 ++++++++++++++++++
 tb/tb_bk_adder_pipe.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared types and helpers for the pipelined Brent-Kung adder.
package bk_pkg;

  localparam int unsigned MaxWidth = 1024;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  function automatic int unsigned bk_levels(int unsigned width);
    return $clog2(width);
  endfunction

  // Prefix operator: hi covers the more significant span.
  function automatic pg_t pg_combine(pg_t hi, pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  // Signed saturation limits for a given width: 0x80..0 when neg, else 0x7F..F.
  function automatic logic [MaxWidth-1:0] sat_const(int unsigned width, logic neg);
    logic [MaxWidth-1:0] msb;
    msb = MaxWidth'(1) << (width - 1);
    return neg ? msb : msb - MaxWidth'(1);
  endfunction

endpackage

// File: rtl/bk_prefix_tree.sv
// Combinational Brent-Kung carry network: up-sweep then down-sweep, c[0] = cin.
module bk_prefix_tree
  import bk_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] g,
  input  logic             cin,
  output logic [WIDTH:0]   c
);

  localparam int unsigned Levels = bk_levels(WIDTH);

  pg_t [Levels:0][WIDTH-1:0]   up;
  pg_t [Levels-1:0][WIDTH-1:0] dn;

  // Carry-in is folded into bit 0 so every prefix already includes it.
  assign up[0][0] = pg_t'{p: p[0], g: g[0] | (p[0] & cin)};
  for (genvar i = 1; i < WIDTH; i++) begin : g_leaf
    assign up[0][i] = pg_t'{p: p[i], g: g[i]};
  end

  for (genvar l = 0; l < Levels; l++) begin : g_up
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i + 1) % (1 << (l + 1))) == 0) begin : g_node
        assign up[l+1][i] = pg_combine(up[l][i], up[l][i-(1<<l)]);
      end else begin : g_pass
        assign up[l+1][i] = up[l][i];
      end
    end
  end

  assign dn[Levels-1] = up[Levels];

  for (genvar d = 0; d < Levels - 1; d++) begin : g_dn
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if ((((i + 1) % (1 << (d + 1))) == (1 << d)) && (i >= (1 << (d + 1)))) begin : g_node
        assign dn[d][i] = pg_combine(dn[d+1][i], dn[d+1][i-(1<<d)]);
      end else begin : g_pass
        assign dn[d][i] = dn[d+1][i];
      end
    end
  end

  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_carry
    assign c[i+1] = dn[0][i].g;
  end

  // Group-propagate terms at the tree edges are intentionally left dangling.
  logic unused_pg;
  assign unused_pg = ^{up, dn};

endmodule

// File: rtl/bk_adder_pipe.sv
// Three-stage pipelined Brent-Kung adder/subtractor with valid/ready flow control.
// Optional signed saturation of the sum is enabled by defining BK_ADDER_PIPE_SAT_EN.
module bk_adder_pipe
  import bk_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  logic             v1_q, v1_d;
  logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
  logic             cin1_q, cin1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  logic             v2_q, v2_d;
  logic [WIDTH-1:0] p2_q, p2_d;
  logic [WIDTH:0]   c2_q, c2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;

  logic             v3_q, v3_d;
  logic [WIDTH-1:0] sum3_q, sum3_d;
  logic             cout3_q, cout3_d, ovf3_q, ovf3_d, zero3_q, zero3_d;
  logic [TAG_W-1:0] tag3_q, tag3_d;

  logic ready1, ready2, ready3;

  // A stage may take new data when empty or when its content moves on this cycle.
  assign ready3   = !v3_q || out_ready;
  assign ready2   = !v2_q || ready3;
  assign ready1   = !v1_q || ready2;
  assign in_ready = ready1;

  always_comb begin
    v1_d   = v1_q;
    a1_d   = a1_q;
    b1_d   = b1_q;
    cin1_d = cin1_q;
    tag1_d = tag1_q;
    if (ready1) v1_d = in_valid;
    if (in_valid && ready1) begin
      a1_d   = in_a;
      b1_d   = in_sub ? ~in_b : in_b;
      cin1_d = in_sub ? 1'b1 : in_cin;
      tag1_d = in_tag;
    end
  end

  logic [WIDTH-1:0] p_w, g_w;
  logic [WIDTH:0]   c_w;

  assign p_w = a1_q ^ b1_q;
  assign g_w = a1_q & b1_q;

  bk_prefix_tree #(
    .WIDTH(WIDTH)
  ) u_prefix_tree (
    .p  (p_w),
    .g  (g_w),
    .cin(cin1_q),
    .c  (c_w)
  );

`ifdef BK_ADDER_PIPE_SAT_EN
  localparam logic [MaxWidth-1:0] SatPosFull = sat_const(WIDTH, 1'b0);
  localparam logic [MaxWidth-1:0] SatNegFull = sat_const(WIDTH, 1'b1);
  localparam logic [WIDTH-1:0]    SatPos     = SatPosFull[WIDTH-1:0];
  localparam logic [WIDTH-1:0]    SatNeg     = SatNegFull[WIDTH-1:0];

  logic sa2_q, sa2_d;
`endif

  always_comb begin
    v2_d   = v2_q;
    p2_d   = p2_q;
    c2_d   = c2_q;
    tag2_d = tag2_q;
`ifdef BK_ADDER_PIPE_SAT_EN
    sa2_d  = sa2_q;
`endif
    if (ready2) v2_d = v1_q;
    if (v1_q && ready2) begin
      p2_d   = p_w;
      c2_d   = c_w;
      tag2_d = tag1_q;
`ifdef BK_ADDER_PIPE_SAT_EN
      sa2_d  = a1_q[WIDTH-1];
`endif
    end
  end

  logic [WIDTH-1:0] sum_raw, sum_fin;
  logic             ovf_raw;

  always_comb begin
    sum_raw = p2_q ^ c2_q[WIDTH-1:0];
    ovf_raw = c2_q[WIDTH] ^ c2_q[WIDTH-1];
    sum_fin = sum_raw;
`ifdef BK_ADDER_PIPE_SAT_EN
    if (ovf_raw) sum_fin = sa2_q ? SatNeg : SatPos;
`endif
  end

  always_comb begin
    v3_d    = v3_q;
    sum3_d  = sum3_q;
    cout3_d = cout3_q;
    ovf3_d  = ovf3_q;
    zero3_d = zero3_q;
    tag3_d  = tag3_q;
    if (ready3) v3_d = v2_q;
    if (v2_q && ready3) begin
      sum3_d  = sum_fin;
      cout3_d = c2_q[WIDTH];
      ovf3_d  = ovf_raw;
      zero3_d = (sum_fin == '0);
      tag3_d  = tag2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      cin1_q  <= 1'b0;
      tag1_q  <= '0;
      v2_q    <= 1'b0;
      p2_q    <= '0;
      c2_q    <= '0;
      tag2_q  <= '0;
`ifdef BK_ADDER_PIPE_SAT_EN
      sa2_q   <= 1'b0;
`endif
      v3_q    <= 1'b0;
      sum3_q  <= '0;
      cout3_q <= 1'b0;
      ovf3_q  <= 1'b0;
      zero3_q <= 1'b0;
      tag3_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      cin1_q  <= cin1_d;
      tag1_q  <= tag1_d;
      v2_q    <= v2_d;
      p2_q    <= p2_d;
      c2_q    <= c2_d;
      tag2_q  <= tag2_d;
`ifdef BK_ADDER_PIPE_SAT_EN
      sa2_q   <= sa2_d;
`endif
      v3_q    <= v3_d;
      sum3_q  <= sum3_d;
      cout3_q <= cout3_d;
      ovf3_q  <= ovf3_d;
      zero3_q <= zero3_d;
      tag3_q  <= tag3_d;
    end
  end

  assign out_valid = v3_q;
  assign out_sum   = sum3_q;
  assign out_cout  = cout3_q;
  assign out_ovf   = ovf3_q;
  assign out_zero  = zero3_q;
  assign out_tag   = tag3_q;

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Directed-vector bench: a 32-bit instance for arithmetic, flow control and reset,
// plus an 8-bit instance swept against a behavioural model under random backpressure.
module tb_bk_adder_pipe;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid32, in_ready32, in_cin32, in_sub32, out_valid32, out_ready32;
  logic [31:0] in_a32, in_b32, out_sum32;
  logic [3:0]  in_tag32, out_tag32;
  logic        out_cout32, out_ovf32, out_zero32;

  logic        in_valid8, in_ready8, in_cin8, in_sub8, out_valid8, out_ready8;
  logic [7:0]  in_a8, in_b8, out_sum8;
  logic [3:0]  in_tag8, out_tag8;
  logic        out_cout8, out_ovf8, out_zero8;

  int n_checks;
  int n_fail;

  bk_adder_pipe #(.WIDTH(32), .TAG_W(4)) u_dut32 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid32),
    .in_ready (in_ready32),
    .in_a     (in_a32),
    .in_b     (in_b32),
    .in_cin   (in_cin32),
    .in_sub   (in_sub32),
    .in_tag   (in_tag32),
    .out_valid(out_valid32),
    .out_ready(out_ready32),
    .out_sum  (out_sum32),
    .out_cout (out_cout32),
    .out_ovf  (out_ovf32),
    .out_zero (out_zero32),
    .out_tag  (out_tag32)
  );

  bk_adder_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid8),
    .in_ready (in_ready8),
    .in_a     (in_a8),
    .in_b     (in_b8),
    .in_cin   (in_cin8),
    .in_sub   (in_sub8),
    .in_tag   (in_tag8),
    .out_valid(out_valid8),
    .out_ready(out_ready8),
    .out_sum  (out_sum8),
    .out_cout (out_cout8),
    .out_ovf  (out_ovf8),
    .out_zero (out_zero8),
    .out_tag  (out_tag8)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } vec32_t;

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
    logic       z;
    logic [3:0] t;
  } exp8_t;

  // Issue one op into an empty 32-bit pipe; lat counts edges from accept to out_valid.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sub, input logic [3:0] tag, output logic [31:0] s,
                       output logic co, output logic ov, output logic z,
                       output logic [3:0] tg, output int lat);
    s = 'x; co = 1'bx; ov = 1'bx; z = 1'bx; tg = 'x; lat = -1;
    in_valid32 = 1'b1; in_a32 = a; in_b32 = b; in_cin32 = cin; in_sub32 = sub;
    in_tag32 = tag; out_ready32 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (in_ready32) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid32) begin
        lat = k; s = out_sum32; co = out_cout32; ov = out_ovf32; z = out_zero32;
        tg = out_tag32;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid32 = 1'b1; in_a32 = 32'h1234_5678; in_b32 = 32'h1; in_cin32 = 1'b1;
    in_sub32 = 1'b0; in_tag32 = 4'hF; out_ready32 = 1'b1;
    in_valid8 = 1'b1; in_a8 = 8'h11; in_b8 = 8'h22; in_cin8 = 1'b0; in_sub8 = 1'b0;
    in_tag8 = 4'h5; out_ready8 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0; in_valid32 = 1'b0; in_valid8 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid32 !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid32: got %b expected 0", out_valid32);
    end
    n_checks++;
    if ({out_sum32, out_cout32, out_ovf32, out_zero32, out_tag32} !== 39'h0) begin
      n_fail++;
      $display("FAIL reset_outputs32: got sum=%h c=%b o=%b z=%b t=%h expected all 0",
               out_sum32, out_cout32, out_ovf32, out_zero32, out_tag32);
    end
    n_checks++;
    if (in_ready32 !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready32: got %b expected 1", in_ready32);
    end
    n_checks++;
    if ({out_valid8, out_sum8, out_tag8} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs8: got v=%b sum=%h t=%h expected 0", out_valid8, out_sum8,
               out_tag8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub();
    vec32_t      v[8];
    logic [31:0] s;
    logic        co, ov, z;
    logic [3:0]  tg;
    int          lat;
    v[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    v[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    v[2] = '{32'h0000_000A, 32'h0000_0014, 1'b1, 1'b0, 32'h0000_001F, 1'b0, 1'b0, 1'b0};
    v[3] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    v[4] = '{32'h7FFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0};
    v[5] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    v[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    v[7] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    foreach (v[i]) begin
      run32(v[i].a, v[i].b, v[i].cin, v[i].sub, 4'(i + 3), s, co, ov, z, tg, lat);
      n_checks++;
      if (lat != 3) begin
        n_fail++; $display("FAIL add_sub[%0d]_latency: got %0d expected 3", i, lat);
      end
      n_checks++;
      if ({s, co, ov, z, tg} !== {v[i].s, v[i].co, v[i].ov, v[i].z, 4'(i + 3)}) begin
        n_fail++;
        $display("FAIL add_sub[%0d]: got sum=%h c=%b o=%b z=%b t=%h expected sum=%h c=%b o=%b z=%b t=%h",
                 i, s, co, ov, z, tg, v[i].s, v[i].co, v[i].ov, v[i].z, 4'(i + 3));
      end
    end
  endtask

  task automatic test_overflow();
    vec32_t      v[3];
    logic [31:0] s;
    logic        co, ov, z;
    logic [3:0]  tg;
    int          lat;
`ifdef BK_ADDER_PIPE_SAT_EN
    v[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    v[1] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
    v[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
`else
    v[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    v[1] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    v[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
`endif
    foreach (v[i]) begin
      run32(v[i].a, v[i].b, v[i].cin, v[i].sub, 4'(i + 12), s, co, ov, z, tg, lat);
      n_checks++;
      if ({s, co, ov, z, tg} !== {v[i].s, v[i].co, v[i].ov, v[i].z, 4'(i + 12)}) begin
        n_fail++;
        $display("FAIL overflow[%0d]: got sum=%h c=%b o=%b z=%b t=%h expected sum=%h c=%b o=%b z=%b t=%h",
                 i, s, co, ov, z, tg, v[i].s, v[i].co, v[i].ov, v[i].z, 4'(i + 12));
      end
    end
  endtask

  task automatic test_backpressure();
    int          next, recv, acc_cnt;
    logic        hold_prev, fell_seen;
    logic [38:0] prev, cur;
    logic [31:0] exp_sum;
    next = 0; recv = 0; acc_cnt = 0; hold_prev = 1'b0; fell_seen = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 60 && recv < 5; cyc++) begin
      in_valid32 = (next < 5); in_a32 = 32'(next) << 4; in_b32 = 32'h1; in_cin32 = 1'b0;
      in_sub32 = 1'b0; in_tag32 = 4'(next); out_ready32 = (cyc >= 10);
      @(negedge clk);
      cur = {out_sum32, out_cout32, out_ovf32, out_zero32, out_tag32};
      if (hold_prev) begin
        n_checks++;
        if (!out_valid32 || cur !== prev) begin
          n_fail++;
          $display("FAIL bp_hold cycle %0d: got v=%b out=%h expected v=1 out=%h", cyc,
                   out_valid32, cur, prev);
        end
      end
      if (in_valid32 && !in_ready32 && !fell_seen) begin
        fell_seen = 1'b1;
        n_checks++;
        if (acc_cnt != 3) begin
          n_fail++; $display("FAIL bp_in_ready_fall: got %0d accepts expected 3", acc_cnt);
        end
      end
      if (out_valid32 && out_ready32) begin
        exp_sum = (32'(recv) << 4) + 32'h1;
        n_checks++;
        if ({out_sum32, out_tag32} !== {exp_sum, 4'(recv)}) begin
          n_fail++;
          $display("FAIL bp_order[%0d]: got sum=%h t=%h expected sum=%h t=%h", recv,
                   out_sum32, out_tag32, exp_sum, 4'(recv));
        end
        recv++;
      end
      hold_prev = out_valid32 && !out_ready32;
      prev = cur;
      if (in_valid32 && in_ready32) begin
        next++; acc_cnt++;
      end
      @(posedge clk); #1;
    end
    in_valid32 = 1'b0;
    n_checks++;
    if (!fell_seen) begin
      n_fail++; $display("FAIL bp_in_ready_low: got never-low expected low after 3 accepts");
    end
    n_checks++;
    if (recv != 5) begin
      n_fail++; $display("FAIL bp_drain_count: got %0d expected 5", recv);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid32 !== 1'b0) begin
        n_fail++; $display("FAIL bp_duplicate: got out_valid=%b expected 0", out_valid32);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] s;
    logic        co, ov, z, stale;
    logic [3:0]  tg;
    int          lat;
    out_ready32 = 1'b1; in_cin32 = 1'b0; in_sub32 = 1'b0;
    in_valid32 = 1'b1; in_a32 = 32'h1; in_b32 = 32'h2; in_tag32 = 4'hA;
    @(posedge clk); #1;
    in_a32 = 32'h3; in_b32 = 32'h4; in_tag32 = 4'hB;
    @(posedge clk); #1;
    // Keep offering during the reset edge: reset must win over the transfer.
    rst = 1'b1; in_a32 = 32'h5; in_tag32 = 4'hC;
    @(posedge clk); #1;
    rst = 1'b0; in_valid32 = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid32, in_ready32} !== 2'b01) begin
      n_fail++;
      $display("FAIL midreset_state: got v=%b rdy=%b expected v=0 rdy=1", out_valid32,
               in_ready32);
    end
    stale = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (out_valid32) stale = 1'b1;
    end
    @(posedge clk); #1;
    n_checks++;
    if (stale !== 1'b0) begin
      n_fail++; $display("FAIL midreset_stale: got stale result expected none");
    end
    run32(32'h0000_0100, 32'h0000_0023, 1'b0, 1'b0, 4'h7, s, co, ov, z, tg, lat);
    n_checks++;
    if ({s, co, ov, z, tg, 8'(lat)} !== {32'h0000_0123, 3'b000, 4'h7, 8'd3}) begin
      n_fail++;
      $display("FAIL midreset_new_op: got sum=%h c=%b o=%b z=%b t=%h lat=%0d expected sum=00000123 t=7 lat=3",
               s, co, ov, z, tg, lat);
    end
  endtask

  task automatic test_w8_sweep();
    logic [7:0] vals[$];
    logic [7:0] a, b, be, s;
    logic [8:0] full;
    logic       cin, sub, ov;
    exp8_t      q[$];
    exp8_t      e;
    int         total, pi, recv, nv;
    for (int i = 0; i < 16; i++) vals.push_back(8'(i * 17));
    vals.push_back(8'h01); vals.push_back(8'h7F); vals.push_back(8'h80); vals.push_back(8'hFE);
    nv = vals.size();
    total = nv * nv * 4;
    pi = 0; recv = 0;
    for (int cyc = 0; cyc < 20000 && recv < total; cyc++) begin
      a = vals[(pi / 4 / nv) % nv]; b = vals[(pi / 4) % nv];
      cin = pi[0]; sub = pi[1];
      in_valid8 = (pi < total) && ($urandom_range(0, 4) != 0);
      in_a8 = a; in_b8 = b; in_cin8 = cin; in_sub8 = sub; in_tag8 = 4'(pi);
      out_ready8 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_valid8 && out_ready8) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL w8_spurious: got t=%h expected no result", out_tag8);
        end else begin
          e = q.pop_front();
          if ({out_sum8, out_cout8, out_ovf8, out_zero8, out_tag8} !==
              {e.s, e.co, e.ov, e.z, e.t}) begin
            n_fail++;
            $display("FAIL w8_result[%0d]: got sum=%h c=%b o=%b z=%b t=%h expected sum=%h c=%b o=%b z=%b t=%h",
                     recv, out_sum8, out_cout8, out_ovf8, out_zero8, out_tag8, e.s, e.co,
                     e.ov, e.z, e.t);
          end
        end
        recv++;
      end
      if (in_valid8 && in_ready8) begin
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + 9'(sub ? 1'b1 : cin);
        s    = full[7:0];
        ov   = (a[7] == be[7]) && (s[7] != a[7]);
`ifdef BK_ADDER_PIPE_SAT_EN
        if (ov) s = a[7] ? 8'h80 : 8'h7F;
`endif
        e.s = s; e.co = full[8]; e.ov = ov; e.z = (s == 8'h00); e.t = 4'(pi);
        q.push_back(e);
        pi++;
      end
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    n_checks++;
    if (recv != total || q.size() != 0) begin
      n_fail++;
      $display("FAIL w8_count: got %0d results (%0d pending) expected %0d", recv, q.size(),
               total);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    in_valid32 = 1'b0; in_a32 = '0; in_b32 = '0; in_cin32 = 1'b0; in_sub32 = 1'b0;
    in_tag32 = '0; out_ready32 = 1'b1;
    in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; in_cin8 = 1'b0; in_sub8 = 1'b0;
    in_tag8 = '0; out_ready8 = 1'b1;
    test_reset();
    test_add_sub();
    test_overflow();
    test_backpressure();
    test_reset_midflight();
    test_w8_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
